// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: core request/response and word-memory port bundle for the load/store unit
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
interface dmem_lsu_if #(parameter int W = `WORD_WIDTH);
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [1:0]   req_size;
  logic         req_signed;
  logic [W-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         resp_valid;
  logic [W-1:0] resp_rdata;
  logic         resp_err;
  logic         mem_read_en;
  logic [W-1:0] mem_read_addr;
  logic [W-1:0] mem_read_data;
  logic         mem_write_en;
  logic [W-1:0] mem_write_addr;
  logic [W-1:0] mem_write_data;
  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_data
  );
  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_data
  );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit with sub-word read-modify-write; define LSU_ALIGN_CHECK_EN to trap misaligned accesses
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
module dmem_lsu #(
  parameter int W          = `WORD_WIDTH,
  parameter bit LITTLE_END = 1'b1
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, LOAD, MERGE, WR, RESP
`ifdef LSU_ALIGN_CHECK_EN
    , ERR
`endif
  } state_t;
  state_t       r_state;
  logic [1:0]   r_addr;
  logic [1:0]   r_size;
  logic         r_signed;
  logic [15:0]  r_wdata;
  logic [W-3:0] r_word_addr;
  logic         r_resp_valid;
  logic         r_resp_err;
  logic [W-1:0] r_resp_rdata;
  logic         r_mem_read_en;
  logic         r_mem_write_en;
  logic [W-1:0] r_mem_write_data;
  logic [1:0]   w_byte_sel;
  logic         w_half_sel;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;
  logic [W-1:0] w_load;
  logic [W-1:0] w_merged;
  logic         w_misalign;
  assign bus.req_ready      = !rst && r_state == IDLE;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_err       = r_resp_err;
  assign bus.resp_rdata     = r_resp_rdata;
  assign bus.mem_read_en    = r_mem_read_en;
  assign bus.mem_write_en   = r_mem_write_en;
  assign bus.mem_read_addr  = {r_word_addr, 2'b00};
  assign bus.mem_write_addr = {r_word_addr, 2'b00};
  assign bus.mem_write_data = r_mem_write_data;
  // Lane numbering follows memory bit order, so big-endian flips the byte index
  assign w_byte_sel = LITTLE_END ? r_addr : ~r_addr;
  assign w_half_sel = LITTLE_END ? r_addr[1] : ~r_addr[1];
  assign w_byte     = bus.mem_read_data[{w_byte_sel, 3'b000} +: 8];
  assign w_half     = bus.mem_read_data[{w_half_sel, 4'b0000} +: 16];
  assign w_load     = r_size == 2'b00 ? {{(W-8){r_signed & w_byte[7]}}, w_byte} :
                      r_size == 2'b01 ? {{(W-16){r_signed & w_half[15]}}, w_half} :
                      bus.mem_read_data;
  always_comb begin
    w_merged = bus.mem_read_data;
    if (r_size == 2'b00)
      w_merged[{w_byte_sel, 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merged[{w_half_sel, 4'b0000} +: 16] = r_wdata;
  end
`ifdef LSU_ALIGN_CHECK_EN
  assign w_misalign = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_size[1] && |bus.req_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_addr           <= '0;
      r_size           <= '0;
      r_signed         <= 1'b0;
      r_wdata          <= '0;
      r_word_addr      <= '0;
      r_resp_valid     <= 1'b0;
      r_resp_err       <= 1'b0;
      r_resp_rdata     <= '0;
      r_mem_read_en    <= 1'b0;
      r_mem_write_en   <= 1'b0;
      r_mem_write_data <= '0;
    end else begin
      r_resp_valid   <= 1'b0;
      r_resp_err     <= 1'b0;
      r_mem_read_en  <= 1'b0;
      r_mem_write_en <= 1'b0;
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_addr       <= bus.req_addr[1:0];
          r_size       <= bus.req_size;
          r_signed     <= bus.req_signed;
          r_wdata      <= bus.req_wdata[15:0];
          r_word_addr  <= bus.req_addr[W-1:2];
          r_resp_rdata <= '0;
`ifdef LSU_ALIGN_CHECK_EN
          if (w_misalign) begin
            r_state      <= ERR;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
          end else
`endif
          if (!bus.req_we) begin
            r_state       <= LOAD;
            r_mem_read_en <= 1'b1;
          end else if (bus.req_size[1]) begin
            r_state          <= WR;
            r_mem_write_en   <= 1'b1;
            r_mem_write_data <= bus.req_wdata;
          end else begin
            r_state       <= MERGE;
            r_mem_read_en <= 1'b1;
          end
        end
        LOAD: begin
          r_resp_rdata <= w_load;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        MERGE: begin
          r_mem_write_data <= w_merged;
          r_mem_write_en   <= 1'b1;
          r_state          <= WR;
        end
        WR: begin
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  logic w_unused;
  assign w_unused = w_misalign;
endmodule
